// File: rtl/joy_port_pkg.sv
// Shared constants and types for the joypad responder: button indices,
// PS/2 scancodes, bus addresses, receiver states and the key map.
package joy_pkg;

   // Bit positions inside joy1/joy2 (1 = pressed)
   localparam logic [2:0] BTN_A      = 3'd0;
   localparam logic [2:0] BTN_B      = 3'd1;
   localparam logic [2:0] BTN_SELECT = 3'd2;
   localparam logic [2:0] BTN_START  = 3'd3;
   localparam logic [2:0] BTN_UP     = 3'd4;
   localparam logic [2:0] BTN_DOWN   = 3'd5;
   localparam logic [2:0] BTN_LEFT   = 3'd6;
   localparam logic [2:0] BTN_RIGHT  = 3'd7;

   // PS/2 set-2 prefixes
   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_F0 = 8'hF0;

   // Player 1 plain keys
   localparam logic [7:0] SC_X     = 8'h22;
   localparam logic [7:0] SC_Z     = 8'h1A;
   localparam logic [7:0] SC_TAB   = 8'h0D;
   localparam logic [7:0] SC_ENTER = 8'h5A;

   // Player 2 plain keys
   localparam logic [7:0] SC_K   = 8'h42;
   localparam logic [7:0] SC_J   = 8'h3B;
   localparam logic [7:0] SC_1   = 8'h16;
   localparam logic [7:0] SC_2   = 8'h1E;
   localparam logic [7:0] SC_W   = 8'h1D;
   localparam logic [7:0] SC_S   = 8'h1B;
   localparam logic [7:0] SC_A   = 8'h1C;
   localparam logic [7:0] SC_D   = 8'h23;

   // Player 1 arrows (only valid after an E0 prefix)
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   // CPU addresses served by this block
   localparam logic [15:0] JOY1_ADDR = 16'h4016;
   localparam logic [15:0] JOY2_ADDR = 16'h4017;

   // PS/2 receiver states
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   // Result of looking up a key code: which player and which button
   typedef struct packed {
      logic       hit;     // code maps to a button
      logic       player;  // 0 = joy1, 1 = joy2
      logic [2:0] btn;     // bit index inside the player's byte
   } key_map_t;

   // Translate a key code (with the extended flag) into a button location.
   // Extended codes use only the arrow table; plain codes use only the
   // letter/number table, so E0 5A (keypad Enter) is deliberately a miss.
   function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
      key_map_t m;
      m = '{hit: 1'b1, player: 1'b0, btn: BTN_A};
      if (ext) begin
         case (code)
            SC_UP:    m.btn = BTN_UP;
            SC_DOWN:  m.btn = BTN_DOWN;
            SC_LEFT:  m.btn = BTN_LEFT;
            SC_RIGHT: m.btn = BTN_RIGHT;
            default:  m.hit = 1'b0;
         endcase
      end else begin
         case (code)
            SC_X:     m.btn = BTN_A;
            SC_Z:     m.btn = BTN_B;
            SC_TAB:   m.btn = BTN_SELECT;
            SC_ENTER: m.btn = BTN_START;
            SC_K:     begin m.player = 1'b1; m.btn = BTN_A;      end
            SC_J:     begin m.player = 1'b1; m.btn = BTN_B;      end
            SC_1:     begin m.player = 1'b1; m.btn = BTN_SELECT; end
            SC_2:     begin m.player = 1'b1; m.btn = BTN_START;  end
            SC_W:     begin m.player = 1'b1; m.btn = BTN_UP;     end
            SC_S:     begin m.player = 1'b1; m.btn = BTN_DOWN;   end
            SC_A:     begin m.player = 1'b1; m.btn = BTN_LEFT;   end
            SC_D:     begin m.player = 1'b1; m.btn = BTN_RIGHT;  end
            default:  m.hit = 1'b0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/joy_port_if.sv
// CPU-side bus seen by the joypad responder. The CPU drives address, data
// and strobes; the responder returns read data and its address-hit flag.
interface joy_port_if;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_o;
   logic        cpu_w;
   logic        cpu_r;
   logic [7:0]  joy_q;
   logic        joy_hit;

   modport master (
      output cpu_a, cpu_o, cpu_w, cpu_r,
      input  joy_q, joy_hit
   );

   modport slave (
      input  cpu_a, cpu_o, cpu_w, cpu_r,
      output joy_q, joy_hit
   );
endinterface

// File: rtl/joy_port_ps2_rx.sv
// PS/2 device-to-host byte receiver. Synchronises the raw line, samples data
// on each falling PS/2 clock, checks odd parity and the stop bit, and emits a
// one-cycle valid pulse per good byte. A stalled frame is dropped after
// TIMEOUT system clocks without a falling edge.
module ps2_rx
   import joy_pkg::*;
#(
   parameter int TIMEOUT = 25000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] data,
   output logic       valid
);

   localparam int             CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

   logic          clk_s1_q, clk_s2_q, clk_s3_q;
   logic          dat_s1_q, dat_s2_q;
   logic          fall;
   logic          timeout;

   rx_state_e     state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          par_q, par_d;
   logic [CW-1:0] idle_q, idle_d;

   // Two-stage synchronisers, plus one extra clock stage for edge detection
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1_q <= 1'b0;
         clk_s2_q <= 1'b0;
         clk_s3_q <= 1'b0;
         dat_s1_q <= 1'b0;
         dat_s2_q <= 1'b0;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_dat;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Synced clock went 1 -> 0; clearing to 0 on reset means an idle-high
   // line produces a rising, never a falling, edge after reset.
   assign fall = clk_s3_q & ~clk_s2_q;

   // Abandon a partial frame once the line has been quiet for too long
   assign timeout = (idle_q == TO_VAL) && !fall && (state_q != RX_IDLE);

   // Idle counter: cleared by every falling edge, saturates at TIMEOUT
   always_comb begin
      idle_d = idle_q;
      if (fall)
         idle_d = '0;
      else if (idle_q != TO_VAL)
         idle_d = idle_q + CW'(1);
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset)
         state_q <= RX_IDLE;
      else
         state_q <= state_d;
   end

   // FSM next state: advance one step per falling edge
   // NOTE: every variable gets a default at the top of a combinational
   // block, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = RX_IDLE;
      end else if (fall) begin
         case (state_q)
            RX_IDLE:   if (!dat_s2_q) state_d = RX_DATA;
            RX_DATA:   if (cnt_q == 3'd7) state_d = RX_PARITY;
            RX_PARITY: state_d = RX_STOP;
            RX_STOP:   state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
         endcase
      end
   end

   // FSM outputs: a good frame needs a high stop bit and odd parity overall
   always_comb begin
      valid = 1'b0;
      if ((state_q == RX_STOP) && fall && dat_s2_q && (^{shift_q, par_q}))
         valid = 1'b1;
   end

   assign data = shift_q;

   // Datapath next state: shift data LSB first, count bits, capture parity
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      if (fall) begin
         case (state_q)
            RX_IDLE:   cnt_d = '0;
            RX_DATA: begin
               shift_d = {dat_s2_q, shift_q[7:1]};
               cnt_d   = cnt_q + 3'd1;
            end
            RX_PARITY: par_d = dat_s2_q;
            default:   ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         idle_q  <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         idle_q  <= idle_d;
      end
   end

endmodule

// File: rtl/joy_port.sv
// Joypad responder for $4016/$4017. Turns PS/2 make/break codes into two NES
// button bytes and serves them to the CPU with strobe/serial-shift semantics.
module joy_port
   import joy_pkg::*;
#(
   parameter int         TIMEOUT = 25000,
   parameter logic [7:0] OPENBUS = 8'h40
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   joy_port_if.slave  bus,
   output logic [7:0] joy1,
   output logic [7:0] joy2
);

   logic [7:0] byte_data;
   logic       byte_valid;
   key_map_t   key;

   logic       ext_q, ext_d;
   logic       brk_q, brk_d;
   logic [7:0] joy1_q, joy1_d;
   logic [7:0] joy2_q, joy2_d;

   logic       strobe_q, strobe_d;
   logic [7:0] sh1_q, sh1_d;
   logic [7:0] sh2_q, sh2_d;

   logic       wr_joy1, rd_joy1, rd_joy2;
   logic       unused_cpu_o;

   ps2_rx #(
      .TIMEOUT (TIMEOUT)
   ) u_rx (
      .clock   (clock),
      .reset   (reset),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .data    (byte_data),
      .valid   (byte_valid)
   );

   assign key = map_key(ext_q, byte_data);

   // Decoder: prefixes set flags, a key code applies them and clears them
   always_comb begin
      ext_d  = ext_q;
      brk_d  = brk_q;
      joy1_d = joy1_q;
      joy2_d = joy2_q;
      if (byte_valid) begin
         if (byte_data == SC_E0) begin
            ext_d = 1'b1;
         end else if (byte_data == SC_F0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (key.hit) begin
               if (key.player)
                  joy2_d[key.btn] = !brk_q;
               else
                  joy1_d[key.btn] = !brk_q;
            end
         end
      end
   end

   // Only bit 0 of a $4016 write is meaningful
   assign unused_cpu_o = ^bus.cpu_o[7:1];

   // Bus decode; $4017 writes belong to the APU frame counter
   assign wr_joy1 = ce && bus.cpu_w && (bus.cpu_a == JOY1_ADDR);
   assign rd_joy1 = ce && bus.cpu_r && !strobe_q && (bus.cpu_a == JOY1_ADDR);
   assign rd_joy2 = ce && bus.cpu_r && !strobe_q && (bus.cpu_a == JOY2_ADDR);

   // Strobe and shift registers: reload while strobed, else shift on read
   // with ones entering at the top so reads past the 8th return 1.
   always_comb begin
      strobe_d = strobe_q;
      sh1_d    = sh1_q;
      sh2_d    = sh2_q;
      if (wr_joy1)
         strobe_d = bus.cpu_o[0];
      if (strobe_q) begin
         // Registered joy values: a key landing this cycle shows up next cycle
         sh1_d = joy1_q;
         sh2_d = joy2_q;
      end else begin
         if (rd_joy1) sh1_d = {1'b1, sh1_q[7:1]};
         if (rd_joy2) sh2_d = {1'b1, sh2_q[7:1]};
      end
   end

   // State registers for decoder, strobe and shift path
   always_ff @(posedge clock) begin
      if (reset) begin
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         joy1_q   <= '0;
         joy2_q   <= '0;
         strobe_q <= 1'b0;
         sh1_q    <= '0;
         sh2_q    <= '0;
      end else begin
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         joy1_q   <= joy1_d;
         joy2_q   <= joy2_d;
         strobe_q <= strobe_d;
         sh1_q    <= sh1_d;
         sh2_q    <= sh2_d;
      end
   end

   // Read mux: open-bus upper bits, serial bit 0 from the addressed register
   always_comb begin
      bus.joy_q   = OPENBUS;
      bus.joy_hit = 1'b0;
      if (bus.cpu_a == JOY1_ADDR) begin
         bus.joy_hit = 1'b1;
         bus.joy_q   = {OPENBUS[7:1], sh1_q[0]};
      end else if (bus.cpu_a == JOY2_ADDR) begin
         bus.joy_hit = 1'b1;
         bus.joy_q   = {OPENBUS[7:1], sh2_q[0]};
      end
   end

   assign joy1 = joy1_q;
   assign joy2 = joy2_q;

endmodule

// File: tb/tb_joy_port.sv
// Directed bench for joy_port: drives PS/2 frames and CPU accesses, keeps a
// byte-stream/button model, and compares the DUT against it every cycle.
module tb_joy_port;

   localparam int TO = 2000;   // receiver timeout used for this bench
   localparam int H  = 6;      // PS/2 half-bit length in system clocks

   logic       clock = 1'b0;
   logic       reset;
   logic       ce;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [7:0] joy1, joy2;

   joy_port_if bus_if();

   joy_port #(.TIMEOUT(TO), .OPENBUS(8'h40)) dut (
      .clock   (clock),
      .reset   (reset),
      .ce      (ce),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .bus     (bus_if),
      .joy1    (joy1),
      .joy2    (joy2)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         key_map[int];      // (ext*256 + code) -> player*8 + button
   logic [7:0] m_joy[2];
   logic       m_ext, m_brk;
   logic       m_strobe;
   logic [7:0] m_latch[2];
   int         m_idx[2];
   bit         m_busy = 1'b0;     // a byte is in flight, joy outputs may move
   bit         q_en = 1'b0;
   logic [7:0] q_exp;
   int         n_valid = 0;

   initial begin
      key_map['h022] = 0;  key_map['h01A] = 1;  key_map['h00D] = 2;  key_map['h05A] = 3;
      key_map['h175] = 4;  key_map['h172] = 5;  key_map['h16B] = 6;  key_map['h174] = 7;
      key_map['h042] = 8;  key_map['h03B] = 9;  key_map['h016] = 10; key_map['h01E] = 11;
      key_map['h01D] = 12; key_map['h01B] = 13; key_map['h01C] = 14; key_map['h023] = 15;
   end

   function automatic void model_reset();
      m_joy[0] = '0; m_joy[1] = '0;
      m_latch[0] = '0; m_latch[1] = '0;
      m_idx[0] = 0; m_idx[1] = 0;
      m_ext = 1'b0; m_brk = 1'b0; m_strobe = 1'b0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int k;
      int v;
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         k = (m_ext ? 256 : 0) + int'(b);
         if (key_map.exists(k)) begin
            v = key_map[k];
            m_joy[v / 8][v % 8] = !m_brk;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   // Expected serial bit for a read of player p; advances the read index
   function automatic logic model_read(input int p);
      logic b;
      if (m_strobe) return m_joy[p][0];
      b = (m_idx[p] >= 8) ? 1'b1 : m_latch[p][m_idx[p]];
      m_idx[p]++;
      return b;
   endfunction

   // Count receiver byte pulses
   always @(posedge clock) if (dut.byte_valid === 1'b1) n_valid++;

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (!reset && !m_busy) begin
         check("joy1", joy1, m_joy[0]);
         check("joy2", joy2, m_joy[1]);
      end
      if (q_en) begin
         check("joy_q", bus_if.joy_q, q_exp);
         check("joy_hit", bus_if.joy_hit, 1'b1);
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      repeat (H) @(posedge clock);
      #1 ps2_clk = 1'b0;
      repeat (H) @(posedge clock);
      #1 ps2_clk = 1'b1;
   endtask

   task automatic ps2_frame(input logic [7:0] d, input bit bad_par);
      logic par;
      par = (~^d) ^ bad_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(par);
      m_busy = 1'b1;
      ps2_bit(1'b1);
      repeat (H) @(posedge clock);
      if (!bad_par) model_byte(d);
      m_busy = 1'b0;
      repeat (2) @(posedge clock);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(posedge clock);
      #1 bus_if.cpu_a = a; bus_if.cpu_o = d; bus_if.cpu_w = 1'b1; ce = 1'b1;
      @(posedge clock);
      #1 bus_if.cpu_w = 1'b0; ce = 1'b0; bus_if.cpu_a = 16'h0000;
      if (a == 16'h4016) begin
         if (m_strobe && !d[0]) begin
            m_latch[0] = m_joy[0]; m_latch[1] = m_joy[1];
            m_idx[0] = 0; m_idx[1] = 0;
         end
         m_strobe = d[0];
      end
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] q);
      logic e;
      @(posedge clock);
      #1 bus_if.cpu_a = a; bus_if.cpu_r = 1'b1; ce = 1'b1;
      e = model_read((a == 16'h4017) ? 1 : 0);
      q_exp = {7'b0100000, e};
      q_en = 1'b1;
      @(negedge clock);
      q = bus_if.joy_q;
      @(posedge clock);
      #1 bus_if.cpu_r = 1'b0; ce = 1'b0; q_en = 1'b0; bus_if.cpu_a = 16'h0000;
   endtask

   // Eight reads into a byte (read i -> bit i) plus the ninth read's bit 0
   task automatic read_seq(input logic [15:0] a, output logic [7:0] seq, output logic ninth);
      logic [7:0] q;
      for (int i = 0; i < 8; i++) begin
         cpu_read(a, q);
         seq[i] = q[0];
      end
      cpu_read(a, q);
      ninth = q[0];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] q, seq;
      logic       ninth;
      int         v0;

      reset = 1'b1; ce = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
      bus_if.cpu_a = 16'h0000; bus_if.cpu_o = 8'h00;
      bus_if.cpu_w = 1'b0; bus_if.cpu_r = 1'b0;
      model_reset();
      do_reset();
      repeat (3) @(posedge clock);

      // Reset state and reads with no strobe
      check("rst_joy1", joy1, 8'h00);
      check("rst_joy2", joy2, 8'h00);
      cpu_read(16'h4016, q);
      check("rst_first_read", q, 8'h40);
      for (int i = 1; i < 8; i++) cpu_read(16'h4016, q);
      check("rst_eighth_read", q, 8'h40);
      cpu_read(16'h4016, q);
      check("rst_ninth_read", q, 8'h41);

      // Make, break, bad parity
      v0 = n_valid;
      ps2_frame(8'h22, 1'b0);
      check("x_make_joy1", joy1, 8'h01);
      check("x_make_valid", n_valid - v0, 1);
      ps2_frame(8'hF0, 1'b0);
      ps2_frame(8'h22, 1'b0);
      check("x_break_joy1", joy1, 8'h00);
      v0 = n_valid;
      ps2_frame(8'h22, 1'b1);
      check("bad_par_joy1", joy1, 8'h00);
      check("bad_par_no_valid", n_valid - v0, 0);

      // Extended arrows, then strobe and serial read of joy1
      ps2_frame(8'hE0, 1'b0); ps2_frame(8'h75, 1'b0);
      ps2_frame(8'hE0, 1'b0); ps2_frame(8'h6B, 1'b0);
      check("arrows_joy1", joy1, 8'h50);
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      read_seq(16'h4016, seq, ninth);
      check("joy1_serial", seq, 8'h50);
      check("joy1_ninth", ninth, 1'b1);

      // Player 2, ignored $4017 write, serial read of joy2
      ps2_frame(8'h42, 1'b0);
      ps2_frame(8'h1D, 1'b0);
      check("p2_joy2", joy2, 8'h11);
      cpu_write(16'h4017, 8'h01);
      cpu_read(16'h4017, q);
      check("w4017_ignored", q, 8'h40);
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      read_seq(16'h4017, seq, ninth);
      check("joy2_serial", seq, 8'h11);
      check("joy2_ninth", ninth, 1'b1);

      // Reads while strobe is held do not shift; key press during strobe
      ps2_frame(8'h22, 1'b0);
      cpu_write(16'h4016, 8'h01);
      for (int i = 0; i < 3; i++) begin
         cpu_read(16'h4016, q);
         check("strobe_hold_read", q, 8'h41);
      end
      ps2_frame(8'h1A, 1'b0);
      check("z_during_strobe", joy1, 8'h53);
      cpu_write(16'h4016, 8'h00);
      cpu_read(16'h4016, q);
      check("after_strobe_A", q, 8'h41);
      cpu_read(16'h4016, q);
      check("after_strobe_B", q, 8'h41);

      // Non-joypad address
      @(posedge clock); #1 bus_if.cpu_a = 16'h4015;
      @(negedge clock);
      check("miss_hit", bus_if.joy_hit, 1'b0);
      check("miss_q", bus_if.joy_q, 8'h40);
      @(posedge clock); #1 bus_if.cpu_a = 16'h0000;

      // Partial frame dropped by timeout, then a clean Enter frame
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
      repeat (TO + 10) @(posedge clock);
      ps2_frame(8'h5A, 1'b0);
      check("timeout_start", joy1, 8'h5B);

      // Reset in the middle of a frame
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
      do_reset();
      bus_if.cpu_a = 16'h4016;
      @(negedge clock);
      check("midrst_joy1", joy1, 8'h00);
      check("midrst_joy2", joy2, 8'h00);
      check("midrst_q", bus_if.joy_q, 8'h40);
      @(posedge clock); #1 bus_if.cpu_a = 16'h0000;
      repeat (TO + 10) @(posedge clock);
      ps2_frame(8'h1C, 1'b0);
      check("resync_joy2", joy2, 8'h40);

      repeat (4) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
